dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory (`DataMem`: asynchronous read, write on the rising clock edge when MemRW=1) between two requesters: port 0 is the core load/store stage, port 1 is the program/data loader. It performs a round-robin grant with a bounded burst and sequences each access through a fixed three-state handshake. It also owns the memory-mapped GPIO output register at `GPIO_ADDR`, so GPIO accesses never reach the memory array. It sits between the requesters and `DataMem` in the top level.

## Interface
- `GPIO_ADDR`, default 32'h0000ABCD: full 32-bit address decoded as the GPIO register.
- `BURST`, default 4: the maximum number of consecutive grants to one port while the other port is requesting. Range 1..15.

Clock is `clock`; reset is `reset_n`, asynchronous and active-low. All other logic is synchronous to the rising edge of `clock`.

- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_req`  in  1  port 0 access request; held until `m0_ack`
- `m0_we`  in  1  port 0: 1 = write, 0 = read
- `m0_addr`  in  32  port 0 byte address
- `m0_wdata`  in  32  port 0 write data
- `m0_ack`  out  1  port 0 one-cycle completion pulse
- `m0_rdata`  out  32  port 0 read data, valid while `m0_ack`=1
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical definitions for port 1
- `mem_addr`  out  32  to DataMem Address
- `mem_wdata`  out  32  to DataMem Wdata
- `mem_we`  out  1  to DataMem MemRW
- `mem_rdata`  in  32  from DataMem Rdata
- `gpio_out`  out  32  GPIO output register
- `busy`  out  1  1 whenever the state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP. Every access takes exactly IDLE→ACCESS→RESP→IDLE.
- **IDLE**
  - If no request is pending, remain in IDLE.
  - Otherwise choose a winner and latch its `we`, `addr` and `wdata` into `mem_we_q`, `mem_addr`, `mem_wdata`. Go to ACCESS.
- **Arbitration**
  - If only one port requests, that port wins.
  - If both request, the port named by the priority pointer `prio` wins.
  - `burst_cnt` counts consecutive grants to the same port. It resets to 1 when the winner changes.
  - When `burst_cnt` reaches `BURST` and the other port is requesting, `prio` flips to the other port. Otherwise `prio` stays on the last winner.
- **ACCESS** (one cycle)
  - `mem_we` = latched `we` AND (latched `addr` != `GPIO_ADDR`).
  - GPIO write: `gpio_out` <= latched `wdata` at the end of the cycle.
  - GPIO read: capture `gpio_out` into `rdata_q`.
  - Memory read: capture `mem_rdata` into `rdata_q`.
  - Memory write: `rdata_q` <= latched `wdata` (write-through echo).
  - Go to RESP.
- **RESP** (one cycle)
  - Assert the winner's ack; both `m0_rdata` and `m1_rdata` are driven from `rdata_q`.
  - Go to IDLE.
  - The requester drops `req` or presents its next request in the cycle after ack.
- `mem_we` is 0 in IDLE and RESP. `mem_addr` and `mem_wdata` hold their latched values outside ACCESS, so they stay stable across the write edge.
- Addresses pass through unmodified. Word selection and alignment are DataMem's responsibility.
- A request is ignored unless the FSM is in IDLE. Inputs are sampled only in IDLE.
- Both acks are never asserted in the same cycle.

## Timing
- Reset values:
  - state = IDLE
  - `m0_ack` = `m1_ack` = 0
  - `m0_rdata` = `m1_rdata` = 0
  - `mem_addr` = `mem_wdata` = 0, `mem_we` = 0
  - `gpio_out` = 0
  - `busy` = 0
  - `prio` = port 0
  - `burst_cnt` = 0
- Latency: a req sampled high in IDLE at edge E puts ACCESS in cycle E+1 and ack in cycle E+2. Throughput is one access per 3 cycles.
- A memory write commits at the rising edge that ends ACCESS.
- Reset mid-operation: `mem_we` and the acks fall immediately, with no registered-clock dependency. A write whose ACCESS edge has not yet occurred is not performed. `gpio_out` returns to 0.
- Simultaneous events:
  - A request arriving in ACCESS or RESP waits for IDLE.
  - If both ports request in the same cycle, `prio` decides.
- `burst_cnt` saturates at `BURST` and must not wrap.

## Test plan
- **Reset / idle:** after reset release, no req for 5 cycles → all outputs at reset values, `busy`=0.
- **Port 0 write then read:** m0 writes 1114 to address 36, then reads 36 → `mem_we`=1 only in the ACCESS cycle, ack 2 cycles after req, read returns 1114.
- **Port 1 read:** m1 reads address 12 with DataMem word 3 preloaded to 0x55 → `m1_ack` with `m1_rdata`=0x55; `m0_ack` stays 0.
- **GPIO:** m0 writes 0xDEAD to 0xABCD → `mem_we` stays 0, `gpio_out`=0xDEAD after ACCESS. A read of 0xABCD then returns 0xDEAD.
- **Contention (`BURST`=4):** both ports hold req continuously → grant sequence 0,0,0,0,1,1,1,1,0… and no double ack.
- **Reset in ACCESS:** m1 writes 0x77 to address 40 and `reset_n` falls mid-ACCESS → `mem_we` drops immediately, DataMem word 10 is unchanged, no ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMem between the core load/store
// stage (port 0) and the program/data loader (port 1). Round-robin grant with
// a bounded burst; every access runs IDLE -> ACCESS -> RESP -> IDLE.
// The GPIO output register lives here, so GPIO accesses never touch DataMem.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; arbitration and latching of the winner
// ACCESS | DataMem (or GPIO register) is accessed; write commits at the end
// RESP   | winner's ack pulses, read data presented from rdata_q

module dmem_arbiter #(
   parameter logic [31:0] GPIO_ADDR = 32'h0000ABCD,
   parameter int          BURST     = 4
) (
   input  logic        clock,
   input  logic        reset_n,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,

   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,

   output logic [31:0] gpio_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] BURST_L = 4'(BURST);

   state_t      state;
   logic        prio;       // port that wins when both request
   logic        gnt;        // port granted for the access in flight
   logic [3:0]  burst_cnt;  // consecutive grants to gnt, saturating at BURST
   logic        mem_we_q;
   logic [31:0] rdata_q;

   logic        win;
   logic        other_req;
   logic [3:0]  cnt_nxt;
   logic        prio_nxt;
   logic        gpio_hit;

   // Winner selection and burst/priority bookkeeping for the next grant.
   always_comb begin
      win       = 1'b0;
      other_req = 1'b0;
      cnt_nxt   = 4'd1;
      prio_nxt  = prio;
      if (m0_req && m1_req)
         win = prio;
      else
         win = m1_req;
      other_req = win ? m0_req : m1_req;
      // burst_cnt == 0 only right after reset: the first grant starts a new run.
      if ((burst_cnt == 4'd0) || (win != gnt))
         cnt_nxt = 4'd1;
      else if (burst_cnt >= BURST_L)
         cnt_nxt = BURST_L;
      else
         cnt_nxt = burst_cnt + 4'd1;
      if ((cnt_nxt == BURST_L) && other_req)
         prio_nxt = ~win;
      else
         prio_nxt = win;
   end

   assign gpio_hit = (mem_addr == GPIO_ADDR);

   // Decoded from the state register so it drops the moment reset asserts.
   assign mem_we   = (state == ACCESS) && mem_we_q && !gpio_hit;
   assign busy     = (state != IDLE);
   assign m0_rdata = rdata_q;
   assign m1_rdata = rdata_q;

   // Access sequencer: arbitration, latching, GPIO register and response.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         gnt       <= 1'b0;
         burst_cnt <= 4'd0;
         mem_we_q  <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         rdata_q   <= 32'd0;
         gpio_out  <= 32'd0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               if (m0_req || m1_req) begin
                  gnt       <= win;
                  burst_cnt <= cnt_nxt;
                  prio      <= prio_nxt;
                  mem_we_q  <= win ? m1_we    : m0_we;
                  mem_addr  <= win ? m1_addr  : m0_addr;
                  mem_wdata <= win ? m1_wdata : m0_wdata;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (mem_we_q && gpio_hit)
                  gpio_out <= mem_wdata;
               // Writes echo their own data back to the requester.
               if (mem_we_q)
                  rdata_q <= mem_wdata;
               else if (gpio_hit)
                  rdata_q <= gpio_out;
               else
                  rdata_q <= mem_rdata;
               m0_ack <= ~gnt;
               m1_ack <= gnt;
               state  <= RESP;
            end
            RESP: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMem model.

module tb_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m0_ack;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m1_ack;
   logic [31:0] m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [31:0] gpio_out;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;

   always #5 clock = ~clock;

   // DataMem model: asynchronous read, write on rising edge; bench preload port.
   always @(posedge clock) begin
      if (pl_en)
         mem[pl_idx] <= pl_val;
      else if (mem_we)
         mem[mem_addr[7:2]] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr[7:2]];

   dmem_arbiter #(.GPIO_ADDR(32'h0000ABCD), .BURST(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .gpio_out(gpio_out), .busy(busy)
   );

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clock);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(posedge clock);
      #1 pl_en = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // One access on one port; returns ack latency in negedges after req (-1 on timeout).
   task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output int lat, output int we_cnt, output logic we_first,
                            output int other_ack);
      rdata = '0; lat = -1; we_cnt = 0; we_first = 1'b0; other_ack = 0;
      @(negedge clock);
      if (port == 0) begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (mem_we) we_cnt++;
         if (i == 1) we_first = mem_we;
         if ((port == 0) ? m1_ack : m0_ack) other_ack++;
         if ((port == 0) ? m0_ack : m1_ack) begin
            lat   = i;
            rdata = (port == 0) ? m0_rdata : m1_rdata;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         n_chk++;
         if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: busy=%b m0_ack=%b m1_ack=%b mem_we=%b, required all 0",
                     c, busy, m0_ack, m1_ack, mem_we);
         end
      end
      n_chk++;
      if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rdata: m0=%h m1=%h, required 0", m0_rdata, m1_rdata);
      end
      n_chk++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || gpio_out !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs: mem_addr=%h mem_wdata=%h gpio_out=%h, required 0",
                  mem_addr, mem_wdata, gpio_out);
      end
   endtask

   task automatic test_port0_write_read();
      logic [31:0] rd; int lat, wec, oth; logic wef;
      do_access(0, 1'b1, 32'd36, 32'd1114, rd, lat, wec, wef, oth);
      n_chk++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL p0_write_latency: got %0d, required 2", lat);
      end
      n_chk++;
      if (wef !== 1'b1 || wec !== 1) begin
         n_fail++;
         $display("FAIL p0_write_mem_we: access-cycle=%b high-cycles=%0d, required 1 and 1", wef, wec);
      end
      n_chk++;
      if (mem[9] !== 32'd1114) begin
         n_fail++; $display("FAIL p0_write_commit: mem[9]=%0d, required 1114", mem[9]);
      end
      n_chk++;
      if (rd !== 32'd1114) begin
         n_fail++; $display("FAIL p0_write_echo: rdata=%0d, required 1114", rd);
      end
      do_access(0, 1'b0, 32'd36, 32'd0, rd, lat, wec, wef, oth);
      n_chk++;
      if (lat !== 2 || rd !== 32'd1114) begin
         n_fail++; $display("FAIL p0_read: latency=%0d rdata=%0d, required 2 and 1114", lat, rd);
      end
      n_chk++;
      if (wec !== 0 || oth !== 0) begin
         n_fail++; $display("FAIL p0_read_side: mem_we cycles=%0d m1_ack=%0d, required 0 and 0", wec, oth);
      end
   endtask

   task automatic test_port1_read();
      logic [31:0] rd; int lat, wec, oth; logic wef;
      preload(6'd3, 32'h55);
      do_access(1, 1'b0, 32'd12, 32'd0, rd, lat, wec, wef, oth);
      n_chk++;
      if (lat !== 2 || rd !== 32'h55) begin
         n_fail++; $display("FAIL p1_read: latency=%0d rdata=%h, required 2 and 55", lat, rd);
      end
      n_chk++;
      if (oth !== 0) begin
         n_fail++; $display("FAIL p1_read_m0_ack: m0_ack cycles=%0d, required 0", oth);
      end
   endtask

   task automatic test_gpio();
      logic [31:0] rd; int lat, wec, oth; logic wef;
      do_access(0, 1'b1, 32'h0000ABCD, 32'h0000DEAD, rd, lat, wec, wef, oth);
      n_chk++;
      if (wec !== 0) begin
         n_fail++; $display("FAIL gpio_write_mem_we: high cycles=%0d, required 0", wec);
      end
      n_chk++;
      if (gpio_out !== 32'h0000DEAD || lat !== 2) begin
         n_fail++; $display("FAIL gpio_write: gpio_out=%h latency=%0d, required dead and 2", gpio_out, lat);
      end
      do_access(0, 1'b0, 32'h0000ABCD, 32'd0, rd, lat, wec, wef, oth);
      n_chk++;
      if (rd !== 32'h0000DEAD) begin
         n_fail++; $display("FAIL gpio_read: rdata=%h, required dead", rd);
      end
   endtask

   task automatic test_contention();
      int seq [9];
      int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      int ng = 0;
      int dbl = 0;
      apply_reset();
      @(negedge clock);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd4;
      for (int c = 0; c < 60 && ng < 9; c++) begin
         @(negedge clock);
         if (m0_ack && m1_ack) dbl++;
         if (m0_ack) begin seq[ng] = 0; ng++; end
         else if (m1_ack) begin seq[ng] = 1; ng++; end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      n_chk++;
      if (ng !== 9) begin
         n_fail++; $display("FAIL contention_count: grants=%0d, required 9", ng);
      end
      for (int k = 0; k < ng; k++) begin
         n_chk++;
         if (seq[k] !== exp_seq[k]) begin
            n_fail++; $display("FAIL contention_grant[%0d]: port %0d, required %0d", k, seq[k], exp_seq[k]);
         end
      end
      n_chk++;
      if (dbl !== 0) begin
         n_fail++; $display("FAIL contention_double_ack: %0d cycles, required 0", dbl);
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset_in_access();
      logic [31:0] rd; int lat, wec, oth; logic wef;
      int acks = 0;
      do_access(0, 1'b1, 32'h0000ABCD, 32'h1, rd, lat, wec, wef, oth);
      n_chk++;
      if (gpio_out !== 32'h1) begin
         n_fail++; $display("FAIL rst_setup_gpio: gpio_out=%h, required 1", gpio_out);
      end
      preload(6'd10, 32'h1234);
      @(negedge clock);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd40; m1_wdata = 32'h77;
      @(posedge clock);
      #2;
      n_chk++;
      if (mem_we !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_access: mem_we=%b busy=%b, required 1 and 1", mem_we, busy);
      end
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (mem_we !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_immediate: mem_we=%b m1_ack=%b busy=%b, required 0", mem_we, m1_ack, busy);
      end
      n_chk++;
      if (gpio_out !== 32'd0) begin
         n_fail++; $display("FAIL rst_gpio: gpio_out=%h, required 0", gpio_out);
      end
      m1_req = 1'b0;
      @(posedge clock);
      #1;
      n_chk++;
      if (mem[10] !== 32'h1234) begin
         n_fail++; $display("FAIL rst_no_write: mem[10]=%h, required 1234", mem[10]);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (m0_ack || m1_ack) acks++;
      end
      n_chk++;
      if (acks !== 0) begin
         n_fail++; $display("FAIL rst_no_ack: ack cycles=%0d, required 0", acks);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_port0_write_read();
      test_port1_read();
      test_gpio();
      test_contention();
      test_reset_in_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
